// File: rtl/clk_gate_ctrl.sv
// Per-channel automatic clock-gating controller: ON -> IDLE -> DRAIN -> OFF -> WAKE
// sequence per channel, each driving a latch-based integrated clock gate.
module clk_gate_ctrl #(
    parameter int N_CH     = 4,
    parameter int IDLE_W   = 8,
    parameter int WAKE_CYC = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                test_en,
    input  logic [IDLE_W-1:0]   cfg_idle_thr,
    input  logic [N_CH-1:0]     cfg_auto_en,
    input  logic [N_CH-1:0]     cfg_force_on,
    input  logic [N_CH-1:0]     ch_busy,
    input  logic [N_CH-1:0]     ch_wake_req,
    input  logic [N_CH-1:0]     ch_off_ack,
    output logic [N_CH-1:0]     ch_off_req,
    output logic [N_CH-1:0]     ch_clk_en,
    output logic [N_CH-1:0]     ch_ready,
    output logic [N_CH-1:0]     gclk,
    output logic [3*N_CH-1:0]   ch_state
);

    typedef enum logic [2:0] {
        S_ON    = 3'd0,
        S_IDLE  = 3'd1,
        S_DRAIN = 3'd2,
        S_OFF   = 3'd3,
        S_WAKE  = 3'd4
    } state_e;

    localparam logic [IDLE_W-1:0] WAKE_LAST = IDLE_W'(WAKE_CYC - 1);

    logic thr_zero_s;
    assign thr_zero_s = (cfg_idle_thr == {IDLE_W{1'b0}});

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        state_e            state_q, state_d;
        logic [IDLE_W-1:0] cnt_q, cnt_d;
        logic              act_s;
        logic              drain_hit_s;
        logic              clk_en_q, ready_q, off_req_q;
        logic              en_lat_q;

        assign act_s = ch_busy[i] | ch_wake_req[i] | cfg_force_on[i] | ~cfg_auto_en[i] | thr_zero_s;
        // Extra bit keeps cnt+1 from wrapping when compared against the live threshold.
        assign drain_hit_s = (({1'b0, cnt_q} + {{IDLE_W{1'b0}}, 1'b1}) >= {1'b0, cfg_idle_thr});

        // Next-state and counter logic for one channel
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            case (state_q)
                S_ON: begin
                    if (!act_s) begin
                        state_d = S_IDLE;
                        cnt_d   = {IDLE_W{1'b0}};
                    end else begin
                        state_d = S_ON;
                    end
                end
                S_IDLE: begin
                    if (act_s) begin
                        state_d = S_ON;
                        cnt_d   = {IDLE_W{1'b0}};
                    end else if (drain_hit_s) begin
                        state_d = S_DRAIN;
                    end else begin
                        cnt_d   = cnt_q + {{(IDLE_W-1){1'b0}}, 1'b1};
                    end
                end
                S_DRAIN: begin
                    if (act_s) begin
                        state_d = S_ON;
                    end else if (ch_off_ack[i]) begin
                        state_d = S_OFF;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
                S_OFF: begin
                    if (act_s) begin
                        state_d = S_WAKE;
                        cnt_d   = {IDLE_W{1'b0}};
                    end else begin
                        state_d = S_OFF;
                    end
                end
                S_WAKE: begin
                    if (cnt_q == WAKE_LAST) begin
                        state_d = S_ON;
                        cnt_d   = {IDLE_W{1'b0}};
                    end else begin
                        cnt_d   = cnt_q + {{(IDLE_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_d = S_ON;
                    cnt_d   = {IDLE_W{1'b0}};
                end
            endcase
        end

        // State register with outputs decoded from the next state
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                state_q   <= S_ON;
                cnt_q     <= {IDLE_W{1'b0}};
                clk_en_q  <= 1'b1;
                ready_q   <= 1'b1;
                off_req_q <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                clk_en_q  <= (state_d != S_OFF);
                ready_q   <= (state_d == S_ON) || (state_d == S_IDLE);
                off_req_q <= (state_d == S_DRAIN);
            end
        end

        // ICG enable latch, transparent while clk is low so gclk cannot glitch
        always_latch begin
            if (!clk) begin
                en_lat_q <= clk_en_q | test_en;
            end
        end

        assign gclk[i]           = clk & en_lat_q;
        assign ch_clk_en[i]      = clk_en_q;
        assign ch_ready[i]       = ready_q;
        assign ch_off_req[i]     = off_req_q;
        assign ch_state[3*i +: 3] = state_q;
    end

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Self-checking bench for clk_gate_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_clk_gate_ctrl;
    localparam int N_CH     = 4;
    localparam int IDLE_W   = 8;
    localparam int WAKE_CYC = 2;

    logic                clk;
    logic                rst_n;
    logic                test_en;
    logic [IDLE_W-1:0]   cfg_idle_thr;
    logic [N_CH-1:0]     cfg_auto_en, cfg_force_on, ch_busy, ch_wake_req, ch_off_ack;
    logic [N_CH-1:0]     ch_off_req, ch_clk_en, ch_ready, gclk;
    logic [3*N_CH-1:0]   ch_state;

    int tests = 0;
    int fails = 0;

    clk_gate_ctrl #(.N_CH(N_CH), .IDLE_W(IDLE_W), .WAKE_CYC(WAKE_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .test_en(test_en), .cfg_idle_thr(cfg_idle_thr),
        .cfg_auto_en(cfg_auto_en), .cfg_force_on(cfg_force_on), .ch_busy(ch_busy),
        .ch_wake_req(ch_wake_req), .ch_off_ack(ch_off_ack), .ch_off_req(ch_off_req),
        .ch_clk_en(ch_clk_en), .ch_ready(ch_ready), .gclk(gclk), .ch_state(ch_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode is the spec state number, idle_run counts idle cycles
    // spent, wake_run counts clocked cycles since wake.
    int mode [N_CH];
    int idle_run [N_CH];
    int wake_run [N_CH];
    bit started = 1'b0;
    bit gclk_valid = 1'b0;
    logic [N_CH-1:0] exp_gclk;

    initial begin
        for (int i = 0; i < N_CH; i++) begin
            mode[i] = 0; idle_run[i] = 0; wake_run[i] = 0;
        end
    end

    always @(posedge clk) begin
        bit act;
        for (int i = 0; i < N_CH; i++) exp_gclk[i] = (mode[i] != 3) || test_en;
        gclk_valid = started;
        for (int i = 0; i < N_CH; i++) begin
            act = ch_busy[i] || ch_wake_req[i] || cfg_force_on[i] || !cfg_auto_en[i] || (cfg_idle_thr == 0);
            if (!rst_n) begin
                mode[i] = 0;
            end else if (mode[i] == 0) begin
                if (!act) begin mode[i] = 1; idle_run[i] = 0; end
            end else if (mode[i] == 1) begin
                if (act) mode[i] = 0;
                else begin
                    idle_run[i]++;
                    if (idle_run[i] >= int'(cfg_idle_thr)) mode[i] = 2;
                end
            end else if (mode[i] == 2) begin
                if (act) mode[i] = 0;
                else if (ch_off_ack[i]) mode[i] = 3;
            end else if (mode[i] == 3) begin
                if (act) begin mode[i] = 4; wake_run[i] = 0; end
            end else begin
                wake_run[i]++;
                if (wake_run[i] == WAKE_CYC) mode[i] = 0;
            end
        end
        started = 1'b1;
    end

    // Every-cycle comparison of registered outputs against the model
    always @(negedge clk) begin
        logic [3*N_CH-1:0] e_st;
        logic [N_CH-1:0] e_en, e_rdy, e_req;
        if (started) begin
            for (int i = 0; i < N_CH; i++) begin
                e_st[3*i +: 3] = 3'(mode[i]);
                e_en[i]  = (mode[i] != 3);
                e_rdy[i] = (mode[i] <= 1);
                e_req[i] = (mode[i] == 2);
            end
            chk("state", 32'(ch_state), 32'(e_st));
            chk("clk_en", 32'(ch_clk_en), 32'(e_en));
            chk("ready", 32'(ch_ready), 32'(e_rdy));
            chk("off_req", 32'(ch_off_req), 32'(e_req));
            chk("gclk_low", 32'(gclk), 32'd0);
        end
    end

    // gclk high phase must follow the enable seen before the edge
    always @(posedge clk) begin
        #1;
        if (gclk_valid) chk("gclk_high", 32'(gclk), 32'(exp_gclk));
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    int seq [6] = '{1, 1, 1, 1, 2, 3};
    bit left;
    bit hit;

    initial begin
        rst_n = 1'b0; test_en = 1'b0; cfg_idle_thr = 8'd4;
        cfg_auto_en = 4'hF; cfg_force_on = 4'h0; ch_busy = 4'h0;
        ch_wake_req = 4'h0; ch_off_ack = 4'hF;
        repeat (3) step();
        chk("rst_state", 32'(ch_state), 32'h000);
        chk("rst_clk_en", 32'(ch_clk_en), 32'hF);
        chk("rst_ready", 32'(ch_ready), 32'hF);
        chk("rst_off_req", 32'(ch_off_req), 32'h0);

        // Auto-gate: ON -> IDLE x4 -> DRAIN -> OFF
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("auto_seq", 32'(ch_state[2:0]), 32'(seq[k]));
        end
        chk("auto_off_en", 32'(ch_clk_en), 32'h0);

        // Wake ch0 with a one-cycle pulse
        ch_wake_req = 4'b0001;
        step();
        ch_wake_req = 4'h0;
        chk("wake_st1", 32'(ch_state[2:0]), 32'd4);
        chk("wake_en1", 32'(ch_clk_en[0]), 32'd1);
        chk("wake_rdy1", 32'(ch_ready[0]), 32'd0);
        step();
        chk("wake_rdy2", 32'(ch_ready[0]), 32'd0);
        step();
        chk("wake_st3", 32'(ch_state[2:0]), 32'd0);
        chk("wake_rdy3", 32'(ch_ready[0]), 32'd1);

        // Abort in DRAIN: busy and off_ack together
        ch_off_ack = 4'h0;
        hit = 1'b0;
        for (int k = 0; k < 20 && !hit; k++) begin
            step();
            hit = (ch_state[2:0] == 3'd2);
        end
        chk("reach_drain", 32'(hit), 32'd1);
        ch_busy = 4'b0001; ch_off_ack = 4'b0001;
        step();
        ch_busy = 4'h0; ch_off_ack = 4'h0;
        chk("abort_st", 32'(ch_state[2:0]), 32'd0);
        chk("abort_req", 32'(ch_off_req[0]), 32'd0);

        // Overrides: force_on, then thr = 0
        cfg_force_on = 4'b0001;
        left = 1'b0;
        repeat (100) begin step(); if (ch_state[2:0] != 3'd0) left = 1'b1; end
        chk("force_hold", 32'(left), 32'd0);
        cfg_force_on = 4'h0; cfg_idle_thr = 8'd0;
        repeat (5) step();
        left = 1'b0;
        repeat (100) begin step(); if (ch_state != 12'h000) left = 1'b1; end
        chk("thr0_hold", 32'(left), 32'd0);

        // test_en while OFF
        cfg_idle_thr = 8'd4; ch_off_ack = 4'hF;
        hit = 1'b0;
        for (int k = 0; k < 30 && !hit; k++) begin
            step();
            hit = (ch_state == 12'h6DB);
        end
        chk("reach_off", 32'(hit), 32'd1);
        test_en = 1'b1;
        repeat (5) step();
        chk("te_state", 32'(ch_state), 32'h6DB);
        @(posedge clk); #1;
        chk("te_gclk", 32'(gclk), 32'hF);
        @(negedge clk);
        test_en = 1'b0;

        // Reset in WAKE
        ch_wake_req = 4'hF;
        step();
        ch_wake_req = 4'h0;
        chk("mid_wake", 32'(ch_state), 32'h924);
        rst_n = 1'b0;
        step();
        chk("mid_rst_st", 32'(ch_state), 32'h000);
        chk("mid_rst_rdy", 32'(ch_ready), 32'hF);
        rst_n = 1'b1;

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < N_CH; i++) begin
                ch_busy[i]      = ($urandom_range(0, 7) == 0);
                ch_wake_req[i]  = ($urandom_range(0, 15) == 0);
                cfg_force_on[i] = ($urandom_range(0, 31) == 0);
                cfg_auto_en[i]  = ($urandom_range(0, 15) != 0);
                ch_off_ack[i]   = ($urandom_range(0, 1) == 0);
            end
            if ($urandom_range(0, 49) == 0) cfg_idle_thr = 8'($urandom_range(0, 6));
            test_en = ($urandom_range(0, 15) == 0);
            rst_n   = ($urandom_range(0, 199) != 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
